// File: rtl/gorkans_input_pkg.sv
// Shared constants for the gorkans input front-end.
// Scancodes, joystick/port bit positions and sequencer states.
package gorkans_input_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [8:0] SC_SPACE = 9'h029;
  localparam logic [8:0] SC_LCTRL = 9'h014;
  localparam logic [8:0] SC_F1    = 9'h005;
  localparam logic [8:0] SC_F2    = 9'h006;

  localparam int JOY_R    = 0;
  localparam int JOY_L    = 1;
  localparam int JOY_D    = 2;
  localparam int JOY_U    = 3;
  localparam int JOY_FIRE = 4;
  localparam int JOY_S1   = 5;
  localparam int JOY_S2   = 6;

  localparam int KB_UP    = 0;
  localparam int KB_DOWN  = 1;
  localparam int KB_LEFT  = 2;
  localparam int KB_RIGHT = 3;
  localparam int KB_SPACE = 4;
  localparam int KB_LCTRL = 5;
  localparam int KB_S1    = 6;
  localparam int KB_S2    = 7;

  localparam int IN0_UP     = 0;
  localparam int IN0_LEFT   = 1;
  localparam int IN0_RIGHT  = 2;
  localparam int IN0_DOWN   = 3;
  localparam int IN0_COIN   = 5;
  localparam int IN1_FIRE   = 4;
  localparam int IN1_START1 = 5;
  localparam int IN1_START2 = 6;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_COIN,
    SEQ_GAP,
    SEQ_START,
    SEQ_RELEASE
  } seq_state_e;

endpackage

// File: rtl/gorkans_input_ctrl_coin_start_seq.sv
// Frame-timed coin-then-start sequencer.
// One start request produces coin, gap, then the chosen start.
module coin_start_seq
  import gorkans_input_pkg::*;
#(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 8,
  parameter int START_FRAMES = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req1,
  input  logic req2,
  input  logic vblank,
  output logic coin,
  output logic start1,
  output logic start2,
  output logic busy
);

  localparam logic [3:0] COIN_LAST  = 4'(COIN_FRAMES - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_FRAMES - 1);
  localparam logic [3:0] START_LAST = 4'(START_FRAMES - 1);

  seq_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic       vblank_q;
  logic       req_q;
  logic       req;
  logic       tick;
  logic       req_rise;

  assign req      = req1 | req2;
  assign tick     = vblank & ~vblank_q;
  assign req_rise = req & ~req_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= SEQ_IDLE;
      cnt_q    <= 4'd0;
      sel_q    <= 1'b0;
      vblank_q <= vblank;
      req_q    <= req;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      vblank_q <= vblank;
      req_q    <= req;
    end
  end

  // sel_q: 0 selects player 1, 1 selects player 2
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (req_rise) begin
          sel_d   = ~req1;
          cnt_d   = 4'd0;
          state_d = SEQ_COIN;
        end
      end
      SEQ_COIN: begin
        if (tick) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == COIN_LAST) begin
            cnt_d   = 4'd0;
            state_d = SEQ_GAP;
          end
        end
      end
      SEQ_GAP: begin
        if (tick) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == GAP_LAST) begin
            cnt_d   = 4'd0;
            state_d = SEQ_START;
          end
        end
      end
      SEQ_START: begin
        if (tick) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == START_LAST) begin
            cnt_d   = 4'd0;
            state_d = SEQ_RELEASE;
          end
        end
      end
      SEQ_RELEASE: begin
        if (!req1 && !req2) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    coin   = (state_q == SEQ_COIN);
    start1 = (state_q == SEQ_START) && !sel_q;
    start2 = (state_q == SEQ_START) && sel_q;
    busy   = (state_q != SEQ_IDLE);
  end

endmodule

// File: rtl/gorkans_input_ctrl.sv
// Keyboard/joystick front-end for the pacman in0/in1 ports.
// Define GORKANS_INPUT_SOCD_EN to neutralise opposing directions.
module gorkans_input_ctrl
  import gorkans_input_pkg::*;
#(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 8,
  parameter int START_FRAMES = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  input  logic        vblank,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic        busy
);

  logic [7:0]  kb_q, kb_d;
  logic        toggle_q;
  logic [7:0]  in0_q, in0_d;
  logic [7:0]  in1_q, in1_d;
  logic        busy_q;
  logic [15:0] joy;
  logic        up, down, left, right;
  logic        fire, req1, req2;
  logic        coin, start1, start2, seq_busy;
  logic        unused_joy;

  assign joy        = joystick_0 | joystick_1;
  assign unused_joy = ^joy[15:7];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      kb_q     <= 8'd0;
      toggle_q <= ps2_key[10];
      in0_q    <= 8'hFF;
      in1_q    <= 8'hFF;
      busy_q   <= 1'b0;
    end else begin
      kb_q     <= kb_d;
      toggle_q <= ps2_key[10];
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      busy_q   <= seq_busy;
    end
  end

  // arrows ignore the ext bit; other keys need an exact match
  always_comb begin
    kb_d = kb_q;
    if (ps2_key[10] != toggle_q) begin
      unique case (1'b1)
        ps2_key[7:0] == SC_UP:    kb_d[KB_UP]    = ps2_key[9];
        ps2_key[7:0] == SC_DOWN:  kb_d[KB_DOWN]  = ps2_key[9];
        ps2_key[7:0] == SC_LEFT:  kb_d[KB_LEFT]  = ps2_key[9];
        ps2_key[7:0] == SC_RIGHT: kb_d[KB_RIGHT] = ps2_key[9];
        ps2_key[8:0] == SC_SPACE: kb_d[KB_SPACE] = ps2_key[9];
        ps2_key[8:0] == SC_LCTRL: kb_d[KB_LCTRL] = ps2_key[9];
        ps2_key[8:0] == SC_F1:    kb_d[KB_S1]    = ps2_key[9];
        ps2_key[8:0] == SC_F2:    kb_d[KB_S2]    = ps2_key[9];
        default: ;
      endcase
    end
  end

  always_comb begin
    if (rotate) begin
      up    = kb_q[KB_LEFT]  | joy[JOY_L];
      down  = kb_q[KB_RIGHT] | joy[JOY_R];
      left  = kb_q[KB_DOWN]  | joy[JOY_D];
      right = kb_q[KB_UP]    | joy[JOY_U];
    end else begin
      up    = kb_q[KB_UP]    | joy[JOY_U];
      down  = kb_q[KB_DOWN]  | joy[JOY_D];
      left  = kb_q[KB_LEFT]  | joy[JOY_L];
      right = kb_q[KB_RIGHT] | joy[JOY_R];
    end
`ifdef GORKANS_INPUT_SOCD_EN
    if (up && down) begin
      up   = 1'b0;
      down = 1'b0;
    end
    if (left && right) begin
      left  = 1'b0;
      right = 1'b0;
    end
`endif
  end

  assign fire = kb_q[KB_SPACE] | kb_q[KB_LCTRL] | joy[JOY_FIRE];
  assign req1 = kb_q[KB_S1] | joy[JOY_S1];
  assign req2 = kb_q[KB_S2] | joy[JOY_S2];

  coin_start_seq #(
    .COIN_FRAMES  (COIN_FRAMES),
    .GAP_FRAMES   (GAP_FRAMES),
    .START_FRAMES (START_FRAMES)
  ) u_seq (
    .clk_sys (clk_sys),
    .reset   (reset),
    .req1    (req1),
    .req2    (req2),
    .vblank  (vblank),
    .coin    (coin),
    .start1  (start1),
    .start2  (start2),
    .busy    (seq_busy)
  );

  always_comb begin
    in0_d = 8'hFF;
    in1_d = 8'hFF;
    in0_d[IN0_UP]     = ~up;
    in0_d[IN0_LEFT]   = ~left;
    in0_d[IN0_RIGHT]  = ~right;
    in0_d[IN0_DOWN]   = ~down;
    in0_d[IN0_COIN]   = ~coin;
    in1_d[IN1_FIRE]   = ~fire;
    in1_d[IN1_START1] = ~start1;
    in1_d[IN1_START2] = ~start2;
  end

  assign in0  = in0_q;
  assign in1  = in1_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_gorkans_input_ctrl.sv
// Directed bench for gorkans_input_ctrl.
// Key decode, merge, rotation, SOCD and the coin/start sequencer.
module tb_gorkans_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic        vblank;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        busy;

  int passed = 0;
  int total  = 0;

  gorkans_input_ctrl dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .rotate     (rotate),
    .vblank     (vblank),
    .in0        (in0),
    .in1        (in1),
    .busy       (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic key(input logic [8:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, code};
    step(1);
  endtask

  task automatic frame();
    vblank = 1'b1;
    step(1);
    vblank = 1'b0;
    step(1);
  endtask

  logic [7:0] socd_exp;

  initial begin
    reset      = 1'b1;
    ps2_key    = 11'd0;
    joystick_0 = 16'd0;
    joystick_1 = 16'd0;
    rotate     = 1'b0;
    vblank     = 1'b0;
    step(2);
    check("rst_in0", in0, 8'hFF);
    check("rst_in1", in1, 8'hFF);
    check("rst_busy", {7'd0, busy}, 8'h00);
    reset = 1'b0;

    repeat (10) frame();
    check("idle_in0", in0, 8'hFF);
    check("idle_in1", in1, 8'hFF);
    check("idle_busy", {7'd0, busy}, 8'h00);

    key(9'h175, 1'b1);
    check("e075_lat1", in0, 8'hFF);
    step(1);
    check("e075_press", in0, 8'hFE);
    key(9'h175, 1'b0);
    step(1);
    check("e075_release", in0, 8'hFF);
    key(9'h075, 1'b1);
    step(1);
    check("075_noext", in0, 8'hFE);
    key(9'h075, 1'b0);
    step(1);

    rotate = 1'b1;
    joystick_0 = 16'h0008;
    step(1);
    check("rot1_up", in0, 8'hFB);
    rotate = 1'b0;
    step(1);
    check("rot0_up", in0, 8'hFE);
    joystick_0 = 16'h0000;
    joystick_1 = 16'h0001;
    step(1);
    check("joy1_right", in0, 8'hFB);
    rotate = 1'b1;
    step(1);
    check("joy1_rot_down", in0, 8'hF7);
    joystick_1 = 16'h0000;
    rotate = 1'b0;
    step(1);
    check("dir_clear", in0, 8'hFF);

    key(9'h029, 1'b1);
    step(1);
    check("space_press", in1, 8'hEF);
    key(9'h014, 1'b1);
    step(1);
    check("ctrl_press", in1, 8'hEF);
    key(9'h029, 1'b0);
    step(1);
    check("space_release", in1, 8'hEF);
    key(9'h014, 1'b0);
    step(1);
    check("ctrl_release", in1, 8'hFF);
    key(9'h129, 1'b1);
    step(1);
    check("ext_space_ign", in1, 8'hFF);
    key(9'h129, 1'b0);

    `ifdef GORKANS_INPUT_SOCD_EN
    socd_exp = 8'hFF;
    `else
    socd_exp = 8'hF0;
    `endif
    joystick_0 = 16'h000F;
    step(1);
    check("socd", in0, socd_exp);
    joystick_0 = 16'h0000;
    step(1);

    key(9'h005, 1'b1);
    step(1);
    check("f1_lat", in0, 8'hFF);
    step(1);
    check("f1_coin", in0, 8'hDF);
    check("f1_busy", {7'd0, busy}, 8'h01);
    key(9'h005, 1'b0);
    key(9'h006, 1'b1);
    key(9'h006, 1'b0);
    for (int i = 0; i < 3; i++) begin
      frame();
      check("coin_hold", in0, 8'hDF);
    end
    frame();
    check("coin_end", in0, 8'hFF);
    check("gap_busy", {7'd0, busy}, 8'h01);
    for (int i = 0; i < 7; i++) begin
      frame();
      check("gap_in1", in1, 8'hFF);
      check("gap_in0", in0, 8'hFF);
    end
    frame();
    check("start1_on", in1, 8'hDF);
    for (int i = 0; i < 3; i++) begin
      frame();
      check("start1_hold", in1, 8'hDF);
      check("start_busy", {7'd0, busy}, 8'h01);
    end
    frame();
    check("start1_off", in1, 8'hFF);
    step(2);
    check("seq_done_busy", {7'd0, busy}, 8'h00);

    joystick_0 = 16'h0040;
    step(2);
    check("p2_coin", in0, 8'hDF);
    repeat (12) frame();
    check("p2_start", in1, 8'hBF);
    reset = 1'b1;
    step(1);
    check("midrst_in0", in0, 8'hFF);
    check("midrst_in1", in1, 8'hFF);
    check("midrst_busy", {7'd0, busy}, 8'h00);
    reset = 1'b0;
    step(3);
    check("postrst_busy", {7'd0, busy}, 8'h00);
    check("postrst_in0", in0, 8'hFF);
    joystick_0 = 16'h0000;
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
